// File: rtl/pipe_skid_stage_pkg.sv
// Shared definitions for the pipeline stage registers: payload defaults,
// the stage-state encoding and a helper that maps a state to its beat count.
package pipe_pkg;

  localparam int          PC_W     = 32;
  localparam int          INST_W   = 32;
  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  typedef enum logic [1:0] {
    ST_EMPTY,
    ST_MAIN,
    ST_FULL
  } stage_state_e;

  function automatic logic [1:0] occ_of(stage_state_e st);
    case (st)
      ST_EMPTY: occ_of = 2'd0;
      ST_MAIN:  occ_of = 2'd1;
      ST_FULL:  occ_of = 2'd2;
      default:  occ_of = 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/pipe_skid_stage_if.sv
// Handshake bundle between two pipeline stages plus the hazard controls.
// The stage itself uses the slave view; whoever drives the stage uses master.
interface pipe_skid_stage_if #(
  parameter int DATA_W = 64
);

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              stall;
  logic              flush;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [1:0]        occupancy;

  modport master (
    output in_valid, in_data, stall, flush, out_ready,
    input  in_ready, out_valid, out_data, occupancy
  );

  modport slave (
    input  in_valid, in_data, stall, flush, out_ready,
    output in_ready, out_valid, out_data, occupancy
  );

endinterface

// File: rtl/pipe_skid_stage_buf.sv
// Two-entry skid buffer: main output register, skid register and the state
// machine tracking how many beats are held. in_ready is registered here.
//
//   state    | meaning
//   ---------+-------------------------------------------------
//   ST_EMPTY | nothing held, main shows the bubble payload
//   ST_MAIN  | one beat held in main and presented downstream
//   ST_FULL  | main presented, a second beat parked in skid
module pipe_skid_buf
  import pipe_pkg::*;
#(
  parameter int                DATA_W     = 64,
  parameter logic [DATA_W-1:0] BUBBLE_VAL = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              acc,
  input  logic              take,
  input  logic [DATA_W-1:0] in_data,
  output stage_state_e      state,
  output logic              in_ready,
  output logic [DATA_W-1:0] main_data
);

  stage_state_e      state_q, state_d;
  logic [DATA_W-1:0] main_q, main_d;
  logic [DATA_W-1:0] skid_q, skid_d;
  logic              ready_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_EMPTY;
      main_q  <= BUBBLE_VAL;
      skid_q  <= BUBBLE_VAL;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
      ready_q <= (state_d != ST_FULL);
    end
  end

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      // a beat offered in this cycle is dropped; upstream treats it as consumed
      state_d = ST_EMPTY;
      main_d  = BUBBLE_VAL;
      skid_d  = BUBBLE_VAL;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (acc) begin
            state_d = ST_MAIN;
            main_d  = in_data;
          end
        end
        ST_MAIN: begin
          if (acc && take) begin
            main_d = in_data;
          end else if (acc) begin
            state_d = ST_FULL;
            skid_d  = in_data;
          end else if (take) begin
            state_d = ST_EMPTY;
            main_d  = BUBBLE_VAL;
          end
        end
        ST_FULL: begin
          if (take) begin
            state_d = ST_MAIN;
            main_d  = skid_q;
            skid_d  = BUBBLE_VAL;
          end
        end
        default: begin
          state_d = ST_EMPTY;
          main_d  = BUBBLE_VAL;
          skid_d  = BUBBLE_VAL;
        end
      endcase
    end
  end

  assign state     = state_q;
  assign in_ready  = ready_q;
  assign main_data = main_q;

endmodule

// File: rtl/pipe_skid_stage.sv
// Parametrised pipeline stage register with valid/ready, stall and flush.
// SKID_EN selects the registered-ready skid buffer or a single latch.
module pipe_skid_stage
  import pipe_pkg::*;
#(
  parameter int                DATA_W     = 64,
  parameter bit                SKID_EN    = 1'b1,
  parameter logic [DATA_W-1:0] BUBBLE_VAL = DATA_W'({32'h0, NOP_INST})
) (
  input logic              clk,
  input logic              rst,
  pipe_skid_stage_if.slave bus
);

  logic acc;
  logic take;

  // stall looks exactly like a downstream that is not ready
  assign take = bus.out_valid & bus.out_ready & ~bus.stall;
  assign acc  = bus.in_valid & bus.in_ready;

  generate
    if (SKID_EN) begin : g_skid
      stage_state_e      state;
      logic              ready_q;
      logic [DATA_W-1:0] main_data;

      pipe_skid_buf #(
        .DATA_W     (DATA_W),
        .BUBBLE_VAL (BUBBLE_VAL)
      ) u_buf (
        .clk       (clk),
        .rst       (rst),
        .flush     (bus.flush),
        .acc       (acc),
        .take      (take),
        .in_data   (bus.in_data),
        .state     (state),
        .in_ready  (ready_q),
        .main_data (main_data)
      );

      assign bus.in_ready  = ready_q;
      assign bus.out_valid = (state != ST_EMPTY);
      assign bus.out_data  = main_data;
      assign bus.occupancy = occ_of(state);
    end else begin : g_single
      logic              valid_q;
      logic [DATA_W-1:0] data_q;

      always_ff @(posedge clk) begin
        if (rst || bus.flush) begin
          valid_q <= 1'b0;
          data_q  <= BUBBLE_VAL;
        end else if (acc) begin
          valid_q <= 1'b1;
          data_q  <= bus.in_data;
        end else if (take) begin
          valid_q <= 1'b0;
          data_q  <= BUBBLE_VAL;
        end
      end

      assign bus.in_ready  = ~valid_q | take;
      assign bus.out_valid = valid_q;
      assign bus.out_data  = data_q;
      assign bus.occupancy = {1'b0, valid_q};
    end
  endgenerate

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Bench for pipe_skid_stage: skid and single-entry instances driven in lockstep,
// compared every cycle against a queue model of the held beats.
module tb_pipe_skid_stage;

  localparam logic [63:0] BUB = 64'h0000_0000_0000_0013;

  logic clk = 1'b0;
  logic rst;
  logic in_valid, stall, flush, out_ready;
  logic [63:0] in_data;

  int n_vec = 0;
  int n_err = 0;

  logic [63:0] q1[$];
  logic [63:0] q0[$];
  bit          rdy1  = 1'b1;
  bit          known = 1'b0;

  always #5 clk = ~clk;

  pipe_skid_stage_if #(.DATA_W(64)) bus1 ();
  pipe_skid_stage_if #(.DATA_W(64)) bus0 ();

  assign bus1.in_valid  = in_valid;
  assign bus1.in_data   = in_data;
  assign bus1.stall     = stall;
  assign bus1.flush     = flush;
  assign bus1.out_ready = out_ready;
  assign bus0.in_valid  = in_valid;
  assign bus0.in_data   = in_data;
  assign bus0.stall     = stall;
  assign bus0.flush     = flush;
  assign bus0.out_ready = out_ready;

  pipe_skid_stage #(.DATA_W(64), .SKID_EN(1'b1)) dut_skid (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  pipe_skid_stage #(.DATA_W(64), .SKID_EN(1'b0)) dut_single (
    .clk (clk),
    .rst (rst),
    .bus (bus0)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // one clock: drive inputs, check against the model mid-cycle, advance the model
  task automatic step(input bit v, input logic [63:0] d, input bit ordy,
                      input bit st, input bit fl, input bit r);
    bit acc1, take1, acc0, take0, ready0;
    in_valid  = v;
    in_data   = d;
    out_ready = ordy;
    stall     = st;
    flush     = fl;
    rst       = r;
    @(negedge clk);
    take1  = (q1.size() > 0) && ordy && !st;
    acc1   = v && rdy1;
    take0  = (q0.size() > 0) && ordy && !st;
    ready0 = (q0.size() == 0) || take0;
    acc0   = v && ready0;
    if (known) begin
      chk("skid.out_valid", {63'd0, bus1.out_valid}, {63'd0, q1.size() > 0});
      chk("skid.out_data", bus1.out_data, (q1.size() > 0) ? q1[0] : BUB);
      chk("skid.occupancy", {62'd0, bus1.occupancy}, 64'(q1.size()));
      chk("skid.in_ready", {63'd0, bus1.in_ready}, {63'd0, rdy1});
      chk("single.out_valid", {63'd0, bus0.out_valid}, {63'd0, q0.size() > 0});
      chk("single.out_data", bus0.out_data, (q0.size() > 0) ? q0[0] : BUB);
      chk("single.occupancy", {62'd0, bus0.occupancy}, 64'(q0.size()));
      chk("single.in_ready", {63'd0, bus0.in_ready}, {63'd0, ready0});
    end
    @(posedge clk);
    if (r || fl) begin
      q1.delete();
      q0.delete();
      rdy1 = 1'b1;
      if (r) known = 1'b1;
    end else begin
      if (take1) void'(q1.pop_front());
      if (acc1) q1.push_back(d);
      rdy1 = (q1.size() < 2);
      if (take0) void'(q0.pop_front());
      if (acc0) q0.push_back(d);
    end
    #1;
  endtask

  logic [63:0] hold_data;
  bit          hold_v;

  initial begin
    in_valid = 0; in_data = '0; out_ready = 0; stall = 0; flush = 0; rst = 1;

    // reset held two cycles
    step(0, 64'h0, 0, 0, 0, 1);
    step(0, 64'h0, 0, 0, 0, 1);
    in_valid = 0; rst = 0;
    #1;
    chk("rst.out_data", bus1.out_data, BUB);
    chk("rst.out_valid", {63'd0, bus1.out_valid}, 64'd0);
    chk("rst.in_ready", {63'd0, bus1.in_ready}, 64'd1);
    chk("rst.occupancy", {62'd0, bus1.occupancy}, 64'd0);

    // streaming at full rate
    step(1, 64'h1000, 1, 0, 0, 0);
    step(1, 64'h1004, 1, 0, 0, 0);
    step(1, 64'h1008, 1, 0, 0, 0);
    chk("stream.data", bus1.out_data, 64'h1008);
    step(0, 64'h0, 1, 0, 0, 0);
    step(0, 64'h0, 1, 0, 0, 0);

    // backpressure: A held, B to skid, C held upstream
    step(1, 64'hA, 0, 0, 0, 0);
    step(1, 64'hB, 0, 0, 0, 0);
    chk("bp.occupancy", {62'd0, bus1.occupancy}, 64'd2);
    chk("bp.in_ready", {63'd0, bus1.in_ready}, 64'd0);
    chk("bp.single_ready", {63'd0, bus0.in_ready}, 64'd0);
    step(1, 64'hC, 0, 0, 0, 0);
    step(1, 64'hC, 1, 0, 0, 0);
    step(1, 64'hC, 1, 0, 0, 0);
    step(0, 64'h0, 1, 0, 0, 0);
    step(0, 64'h0, 1, 0, 0, 0);
    step(0, 64'h0, 1, 0, 0, 0);

    // stall three cycles with out_ready high
    step(1, 64'h20, 1, 0, 0, 0);
    step(1, 64'h24, 1, 1, 0, 0);
    step(0, 64'h0, 1, 1, 0, 0);
    step(0, 64'h0, 1, 1, 0, 0);
    chk("stall.frozen", bus1.out_data, 64'h20);
    step(0, 64'h0, 1, 0, 0, 0);
    step(0, 64'h0, 1, 0, 0, 0);
    step(0, 64'h0, 1, 0, 0, 0);

    // flush while full with a beat offered
    step(1, 64'h30, 0, 0, 0, 0);
    step(1, 64'h34, 0, 0, 0, 0);
    step(1, 64'h38, 0, 1, 1, 0);
    chk("flush.occupancy", {62'd0, bus1.occupancy}, 64'd0);
    chk("flush.out_valid", {63'd0, bus1.out_valid}, 64'd0);
    chk("flush.out_data", bus1.out_data, BUB);
    chk("flush.in_ready", {63'd0, bus1.in_ready}, 64'd1);
    step(0, 64'h0, 1, 0, 0, 0);

    // randomized traffic; upstream keeps an unaccepted beat on the skid side
    hold_v = 0;
    hold_data = '0;
    for (int i = 0; i < 600; i++) begin
      bit v, ordy, st, fl, r;
      logic [63:0] d;
      v    = ($urandom_range(0, 3) != 0);
      ordy = ($urandom_range(0, 2) != 0);
      st   = ($urandom_range(0, 5) == 0);
      fl   = ($urandom_range(0, 24) == 0);
      r    = ($urandom_range(0, 79) == 0);
      d    = {$urandom(), $urandom()};
      if (hold_v) begin
        v = 1'b1;
        d = hold_data;
      end
      hold_v    = v && !rdy1 && !fl && !r;
      hold_data = d;
      step(v, d, ordy, st, fl, r);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
